// File: rtl/led_pkg.sv
// Shared types and default sizing for the LED panel serializer.
// The LED_PISO_LATCH_EN build macro is consumed by led_piso_mux.
package led_pkg;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } led_state_e;
endpackage

// File: rtl/led_chan_shifter.sv
// One channel word: parallel load, left shift with zero fill, MSB tap.
module led_chan_shifter
  import led_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              shift_en,
  output logic              msb
);
  logic [WORD_W-1:0] sr;

  // load wins so a frame-end reload can coincide with the final shift
  always_ff @(posedge clk) begin
    if (rst)           sr <= '0;
    else if (load)     sr <= load_data;
    else if (shift_en) sr <= {sr[WORD_W-2:0], 1'b0};
  end

  assign msb = sr[WORD_W-1];
endmodule

// File: rtl/led_piso_mux.sv
// Frame-buffered parallel-in/serial-out mux for LED panels, channel 0 first, MSB first.
// Define LED_PISO_LATCH_EN to insert a one-cycle latch strobe after every frame.
module led_piso_mux
  import led_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [NUM_CH*WORD_W-1:0] data_in,
  output logic                     data_out,
  output logic                     data_valid,
  output logic                     frame_done,
  output logic                     latch
);
  localparam int BIT_W = $clog2(WORD_W);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

  led_state_e                     state;
  logic [NUM_CH-1:0][WORD_W-1:0]  pend, src;
  logic                           pend_full, accept, last_bit, have_next, reload;
  logic [BIT_W-1:0]               bit_cnt;
  logic [CH_W-1:0]                ch_cnt;
  logic [NUM_CH-1:0]              msb, shift_en;

  assign load_ready = !pend_full && !rst;
  assign accept     = load_valid && load_ready;
  assign have_next  = pend_full || accept;
  // with the pending slot empty, a same-edge load bypasses straight into the shifters
  assign src        = pend_full ? pend : data_in;
  assign last_bit   = (state == SHIFT) && (bit_cnt == BIT_LAST) && (ch_cnt == CH_LAST);

`ifdef LED_PISO_LATCH_EN
  assign reload = ((state == IDLE) && pend_full) || ((state == LATCH) && have_next);
`else
  assign reload = ((state == IDLE) && pend_full) || (last_bit && have_next);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= '0;
      pend_full <= 1'b0;
    end else if (reload && pend_full) begin
      pend_full <= 1'b0;
    end else if (accept && !reload) begin
      pend      <= data_in;
      pend_full <= 1'b1;
    end
  end

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      assign shift_en[i] = (state == SHIFT) && (ch_cnt == CH_W'(i));
      led_chan_shifter #(.WORD_W(WORD_W)) u_sh (
        .clk       (clk),
        .rst       (rst),
        .load      (reload),
        .load_data (src[i]),
        .shift_en  (shift_en[i]),
        .msb       (msb[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      ch_cnt     <= '0;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pend_full) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            ch_cnt  <= '0;
          end
        end
        SHIFT: begin
          data_out   <= msb[ch_cnt];
          data_valid <= 1'b1;
          frame_done <= last_bit;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            ch_cnt  <= (ch_cnt == CH_LAST) ? '0 : ch_cnt + CH_W'(1);
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
          if (last_bit) begin
`ifdef LED_PISO_LATCH_EN
            state <= LATCH;
`else
            state <= have_next ? SHIFT : IDLE;
`endif
          end
        end
`ifdef LED_PISO_LATCH_EN
        LATCH: state <= have_next ? SHIFT : IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LED_PISO_LATCH_EN
  logic latch_q;
  always_ff @(posedge clk) begin
    if (rst) latch_q <= 1'b0;
    else     latch_q <= (state == LATCH);
  end
  assign latch = latch_q;
`else
  assign latch = 1'b0;
`endif
endmodule

// File: tb/tb_led_piso_mux.sv
// Scoreboard bench: driver pushes the expected serial stream of each accepted frame,
// a negedge monitor pops and compares whenever data_valid is presented.
module tb_led_piso_mux;
  localparam int NUM_CH = 4;
  localparam int WORD_W = 32;
  localparam int FR     = NUM_CH * WORD_W;
`ifdef LED_PISO_LATCH_EN
  localparam bit LATCH_MODE = 1'b1;
`else
  localparam bit LATCH_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [FR-1:0] data_in = '0;
  logic          data_out, data_valid, frame_done, latch;

  logic       lv2 = 1'b0;
  logic       lr2;
  logic [1:0] d2 = '0;
  logic       o2, dv2, fd2, lt2;

  led_piso_mux #(.NUM_CH(NUM_CH), .WORD_W(WORD_W)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
    .frame_done(frame_done), .latch(latch));

  led_piso_mux #(.NUM_CH(1), .WORD_W(2)) dut2 (
    .clk(clk), .rst(rst), .load_valid(lv2), .load_ready(lr2),
    .data_in(d2), .data_out(o2), .data_valid(dv2),
    .frame_done(fd2), .latch(lt2));

  int vec = 0;
  int err = 0;
  bit exp_q[$];
  bit last_q[$];
  int run_len = 0;
  int last_run = 0;
  bit prev_fd = 1'b0;
  bit gap_exp = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference stream: channel 0 first, each word MSB first, last flag on the final bit
  task automatic push_frame(input logic [FR-1:0] d);
    for (int ch = 0; ch < NUM_CH; ch++)
      for (int b = WORD_W - 1; b >= 0; b--) begin
        exp_q.push_back(d[ch*WORD_W + b]);
        last_q.push_back(ch == NUM_CH - 1 && b == 0);
      end
  endtask

  function automatic logic [FR-1:0] rnd_frame();
    logic [FR-1:0] d;
    for (int i = 0; i < FR / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic offer(input logic [FR-1:0] d, output int waited);
    bit acc, done;
    load_valid = 1'b1;
    data_in    = d;
    waited     = 0;
    done       = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      acc = load_ready;
      @(posedge clk); #1;
      if (acc) begin
        push_frame(d);
        done = 1'b1;
      end else waited++;
    end
    load_valid = 1'b0;
    if (!done) chk("offer_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !data_valid && run_len == 0) ok = 1'b1;
    end
    if (!ok) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic wait_run(input int n);
    bit ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk); #1;
      if (run_len == n) ok = 1'b1;
    end
    if (!ok) chk("run_timeout", run_len, n);
  endtask

  always @(negedge clk) begin
    bit eb, el;
    if (rst) begin
      run_len = 0;
      prev_fd = 1'b0;
      gap_exp = 1'b0;
    end else begin
      chk("latch", latch, LATCH_MODE && prev_fd);
      if (gap_exp) chk("gap", data_valid, 1);
      gap_exp = 1'b0;
      if (data_valid) begin
        run_len++;
        if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          eb = exp_q.pop_front();
          el = last_q.pop_front();
          chk("data_out", data_out, eb);
          chk("frame_done", frame_done, el);
          if (el && !LATCH_MODE && exp_q.size() > 0) gap_exp = 1'b1;
        end
      end else begin
        if (run_len > 0) begin
          last_run = run_len;
          run_len  = 0;
        end
        chk("idle_data_out", data_out, 0);
        chk("idle_frame_done", frame_done, 0);
      end
      prev_fd = frame_done && data_valid;
    end
  end

  initial begin
    logic [FR-1:0] d;
    int w;
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FR-1:0] d;
    int w;

    // reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", load_ready, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_fdone", frame_done, 0);
    chk("rst_latch", latch, 0);
    chk("rst_ready2", lr2, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", load_ready, 1);

    // single frame with ch0 = 0x80000001, plus acceptance-to-valid latency
    @(posedge clk); #1;
    d = '0;
    d[31:0] = 32'h8000_0001;
    offer(d, w);
    @(negedge clk); chk("lat_e1", data_valid, 0);
    @(negedge clk); chk("lat_e2", data_valid, 0);
    @(negedge clk); chk("lat_e3", data_valid, 1);
    wait_idle();
    chk("run_single", last_run, FR);

    // load on the frame_done edge with pending empty: bypass reload
    @(posedge clk); #1;
    offer(rnd_frame(), w);
    wait_run(FR - 1);
    chk("pend_empty", load_ready, 1);
    offer(rnd_frame(), w);
    chk("bypass_wait", w, 0);
    wait_idle();
    chk("run_bypass", last_run, LATCH_MODE ? FR : 2 * FR);

    // second frame mid-shift is buffered, third stalls until the reload
    @(posedge clk); #1;
    offer(rnd_frame(), w);
    wait_run(10);
    offer(rnd_frame(), w);
    chk("mid_accept_wait", w, 0);
    chk("ready_drops", load_ready, 0);
    offer(rnd_frame(), w);
    chk("third_stalls", w > 50, 1);
    wait_idle();
    chk("run_three", last_run, LATCH_MODE ? FR : 3 * FR);

    // random frames with random spacing
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 150)) @(posedge clk);
      #1;
      offer(rnd_frame(), w);
    end
    wait_idle();

    // reset in the middle of a frame with a second frame pending
    @(posedge clk); #1;
    offer(rnd_frame(), w);
    offer(rnd_frame(), w);
    wait_run(50);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", data_valid, 0);
    chk("midrst_dout", data_out, 0);
    chk("midrst_fdone", frame_done, 0);
    chk("midrst_latch", latch, 0);
    chk("midrst_ready", load_ready, 0);
    @(negedge clk); #1;
    exp_q.delete();
    last_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("pend_discarded", load_ready, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_rst_quiet", data_valid, 0);
    end
    @(posedge clk); #1;
    d = rnd_frame();
    d[WORD_W-1] = 1'b1;
    offer(d, w);
    wait_idle();
    chk("run_after_rst", last_run, FR);

    // single channel, 2-bit word: 0b10 -> 1 then 0
    @(posedge clk); #1;
    chk("tiny_ready", lr2, 1);
    lv2 = 1'b1;
    d2  = 2'b10;
    @(posedge clk); #1;
    lv2 = 1'b0;
    @(negedge clk); chk("tiny_n1_valid", dv2, 0);
    @(negedge clk); chk("tiny_n2_valid", dv2, 0);
    @(negedge clk);
    chk("tiny_b1_valid", dv2, 1);
    chk("tiny_b1_dout", o2, 1);
    chk("tiny_b1_fdone", fd2, 0);
    @(negedge clk);
    chk("tiny_b2_valid", dv2, 1);
    chk("tiny_b2_dout", o2, 0);
    chk("tiny_b2_fdone", fd2, 1);
    @(negedge clk);
    chk("tiny_after_valid", dv2, 0);
    chk("tiny_after_dout", o2, 0);
    repeat (3) @(negedge clk);
    chk("tiny_idle_valid", dv2, 0);
    chk("tiny_idle_ready", lr2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/led_piso_mux.md
LED_PISO_MUX -- requirements
Module: led_piso_mux

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of channel words per frame (>=1).
REQ-002 SHALL have parameter WORD_W, default 32, bits per channel word (>=2).
REQ-003 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port load_valid  input  1  frame offered on data_in.
REQ-006 SHALL have port load_ready  output  1  pending buffer can accept a frame.
REQ-007 SHALL have port data_in  input  NUM_CH*WORD_W  frame; channel 0 occupies bits [WORD_W-1:0].
REQ-008 SHALL have port data_out  output  1  serial bit, MSB first, registered.
REQ-009 SHALL have port data_valid  output  1  data_out carries a frame bit this cycle.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse with the last bit of a frame.
REQ-011 SHALL have port latch  output  1  panel latch strobe (see Configuration).

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and LATCH; LATCH is reachable only with the Configuration macro defined.
REQ-013 SHALL accept a frame into the pending buffer on any edge where load_valid && load_ready; load_ready = !pend_full.
REQ-014 SHALL, in IDLE with pend_full set, move pending to the active registers, clear pend_full and enter SHIFT on the same edge.
REQ-015 SHALL, in SHIFT, on each edge drive data_out <= active[ch][WORD_W-1], shift that channel left with zero fill, and set data_valid=1.
REQ-016 SHALL emit channels in order 0..NUM_CH-1, WORD_W bits each; data_valid stays high for NUM_CH*WORD_W consecutive cycles per frame.
REQ-017 SHALL assert frame_done in the same cycle as the last bit (channel NUM_CH-1, bit 0).
REQ-018 SHALL, at frame end without the macro, either reload from pending (pend_full, or a load accepted on that same edge, by bypass) and continue SHIFT with zero gap, or go to IDLE.
REQ-019 SHALL give 2-edge latency from load acceptance in IDLE to the first data_valid cycle.
REQ-020 SHALL drive data_out=0 and data_valid=0 whenever no frame bit is being emitted.
REQ-021 SHALL size the bit counter to $clog2(WORD_W) bits and the channel counter to max(1,$clog2(NUM_CH)) bits, with wrap at WORD_W-1 and NUM_CH-1 respectively.
REQ-022 SHALL leave in-flight active data unaffected by a load accepted during SHIFT.

Reset
REQ-023 SHALL, on rst, set state=IDLE, clear all active and pending registers, pend_full and counters, and drive data_out, data_valid, frame_done and latch to 0 after the edge.
REQ-024 SHALL hold load_ready=0 while rst is high, and discard any frame in flight or pending on reset.

Configuration
REQ-025 SHALL, with LED_PISO_LATCH_EN defined, insert one LATCH cycle after every frame's last bit: latch=1, data_valid=0, data_out=0, followed by the REQ-018 decision.
REQ-026 SHALL, without LED_PISO_LATCH_EN, tie latch to 0 and never reach LATCH; frames run back-to-back.

Structure
REQ-027 SHALL place the state enum type and the default NUM_CH/WORD_W localparams in package led_pkg.
REQ-028 SHALL use sub-module led_chan_shifter (WORD_W-bit register with load, shift-enable and msb output), instantiated NUM_CH times.

Verification (NUM_CH=4, WORD_W=32 unless stated)
REQ-029 SHALL cover: one frame {ch0=0x80000001, others 0} -> data_valid for 128 cycles; data_out=1 on cycles 1 and 32, 0 elsewhere; frame_done on cycle 128.
REQ-030 SHALL cover: a second frame offered mid-SHIFT, then a third -> second accepted (load_ready drops), third stalls until reload; no gap between frames without the macro.
REQ-031 SHALL cover: load asserted on the frame_done edge with pending empty -> bypass reload; data_valid stays continuous for 256 cycles.
REQ-032 SHALL cover: rst at bit 50 of a frame -> after the edge all outputs are 0 and state is IDLE; pending is discarded; the next load restarts at ch0 MSB.
REQ-033 SHALL cover: LED_PISO_LATCH_EN with NUM_CH=2, WORD_W=8, two back-to-back frames -> 16 valid bits, 1 latch cycle, 16 valid bits, 1 latch cycle.
REQ-034 SHALL cover: NUM_CH=1, WORD_W=2, data 0b10 -> bits 1,0; frame_done on bit 2; return to IDLE.
